// File: rtl/strobe_period_meter.sv
// Measures enabled ticks between successive strobe pulses and offers each result
// on a valid/ready output; a result completed while one is still held is dropped.
module strobe_period_meter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             strobe_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overflow,
  output logic             overrun,
  output logic             armed
);

  typedef enum logic [0:0] {
    StIdle,
    StMeasure
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] count;
  logic             sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      count        <= '0;
      sat          <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      overrun      <= 1'b0;
      armed        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        StIdle: begin
          count <= '0;
          sat   <= 1'b0;
          if (strobe_in) begin
            state <= StMeasure;
            armed <= 1'b1;
            count <= WIDTH'(enable);
          end
        end
        StMeasure: begin
          if (strobe_in) begin
            // The strobe cycle's own tick belongs to the next interval.
            count <= WIDTH'(enable);
            sat   <= 1'b0;
            if (!period_valid || period_ready) begin
              period       <= count;
              overflow     <= sat;
              period_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            if (enable) begin
              if (&count) begin
                sat <= 1'b1;
              end else begin
                count <= count + WIDTH'(1);
              end
            end
            if (period_valid && period_ready) begin
              period_valid <= 1'b0;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
